uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin transmit arbiter that shares one `uart_protocol` transmit path among `NUM_REQ` byte-stream requesters. It grants the TX FIFO write port to one requester at a time and holds the grant for a packet, which ends on `req_last` or at `MAX_BURST` bytes. Writes are paced against the UART TX status register so the FIFO is never written while full. It sits between on-chip byte producers and `uart_protocol.write_data`/`bus_data_in`.

## Interface
- `DATA_SIZE`, 8, byte width; matches `uart_protocol`.
- `NUM_REQ`, 4, number of requesters (2..16).
- `MAX_BURST`, 16, maximum bytes per grant before forced release (≥1).
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `req` input NUM_REQ: per-requester byte-valid; held until acked.
- `req_data` input NUM_REQ*DATA_SIZE: requester i byte at `[i*DATA_SIZE +: DATA_SIZE]`.
- `req_last` input NUM_REQ: marks the current byte as the final byte of the packet.
- `req_ack` output NUM_REQ: one-cycle pulse; the byte of requester i has been accepted.
- `grant` output NUM_REQ: one-hot current owner; all-zero when idle.
- `busy` output 1: high in any state except IDLE.
- `write_data` output 1: one-cycle write strobe to `uart_protocol`.
- `bus_data_in` output DATA_SIZE: byte to `uart_protocol`, valid while `write_data` is high.
- `tx_status` input 8: `uart_protocol` TX_status_register; bit0 = error_write_data, bit1 = full, bit2 = empty.
- `write_error` output 1: one-cycle pulse when a write was rejected (bit0 seen set after the write).

## Operation
- States:
  - IDLE: no owner.
  - SEND: owner selected, waiting for a byte and FIFO space.
  - STROBE: `write_data` high.
  - SETTLE: one cycle for the status register to update.
- IDLE → SEND: when any `req` bit is high.
  - The owner is the first set bit scanning from `ptr+1` upward, wrapping modulo NUM_REQ.
  - `grant` and `ptr` update to the winner at that edge.
  - Burst counter clears to 0.
- SEND:
  - If `req[g]` is 0 → IDLE. This abandons the packet; `grant` clears.
  - Else if `tx_status[1]` is 1 → stay in SEND. This is full backpressure and has no time-out.
  - Else, at the clock edge: capture `req_data[g]` into `bus_data_in`, set `write_data` and `req_ack[g]`, latch `req_last[g]`, increment the burst counter, and go → STROBE.
- STROBE (exactly 1 cycle):
  - `write_data` and `req_ack` are high.
  - The requester presents the next byte (or drops `req`) by the following edge.
  - Next state is SETTLE; `write_data` and `req_ack` clear.
- SETTLE (exactly 1 cycle), at its end:
  - If `tx_status[0]` is 1, pulse `write_error` in the next cycle. The byte is not retried.
  - If the latched last is set, or the burst count equals MAX_BURST → IDLE, and `grant` clears.
  - Otherwise → SEND with the same owner.
- Burst counter:
  - Width is `$clog2(MAX_BURST+1)`.
  - It never exceeds MAX_BURST and is cleared on every new grant.
- Round-robin rule: after a release, the next winner is the lowest index strictly after the previous owner that has `req` set. The previous owner wins again only if no other requester is asking.
- Simultaneous requests: the arbiter grants one requester only; the others wait in IDLE-order.
- `req`/`req_last` of non-owners are ignored.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - `grant`=0, `busy`=0, `write_data`=0, `bus_data_in`=0, `req_ack`=0, `write_error`=0.
  - `ptr`=NUM_REQ-1, so requester 0 has first priority.
  - Burst counter 0.
- Reset asserted mid-packet aborts immediately. No strobe is emitted while reset is high or in the cycle reset deasserts.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Arbitration latency: `req` high at edge N (IDLE) → `grant` at N; first `write_data` at edge N+1 if the FIFO is not full.
- Throughput: at most one byte per 3 cycles within a packet (SEND, STROBE, SETTLE).
- Handshake:
  - Requester holds `req`, `req_data` and `req_last` stable until it sees `req_ack`.
  - It updates them at the edge that ends the ack cycle.
- `write_error` is sampled at the end of SETTLE and asserts the following cycle. It may overlap the next SEND.

## Test plan
- Single requester 0 sends 0xA5, 0x3C, 0x7E with last on 0x7E:
  - Three `write_data` strobes, 3 cycles apart, with matching `bus_data_in`.
  - `grant`=4'b0001 throughout; IDLE after the third byte.
- Requesters 1 and 2 request together, each with 2-byte packets:
  - Requester 1 is served fully, then requester 2.
  - Next simultaneous 0/1/2 requests are served in the order 2→0→1? No: after 2, order is 0 then 1; ptr wraps correctly.
- `tx_status[1]`=1 held for 50 cycles while requester 0 is pending:
  - No strobe and no ack during the hold.
  - A strobe occurs on the first edge after full clears.
- MAX_BURST=16, requester 3 streams 20 bytes with no last while requester 0 also requests:
  - Requester 3 is released after 16 acks.
  - Requester 0 is granted next; requester 3 resumes afterward.
- `tx_status[0]` forced to 1 during SETTLE → single `write_error` pulse, and the packet continues.
- Reset asserted during STROBE → all outputs 0 on the same cycle; after release, requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_protocol TX FIFO write port among NUM_REQ byte streams.
// States: IDLE no owner | SEND owner waits for byte + FIFO space | STROBE write_data high | SETTLE status update.
module uart_tx_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o,
    output logic                         write_data_o,
    output logic [DATA_SIZE-1:0]         bus_data_in_o,
    input  logic [7:0]                   tx_status_i,
    output logic                         write_error_o
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_STROBE,
        ST_SETTLE
    } state_t;

    state_t                 state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [BURST_W-1:0]     burst_q;
    logic                   last_q;
    logic                   busy_q;
    logic                   write_data_q;
    logic [DATA_SIZE-1:0]   bus_data_q;
    logic [NUM_REQ-1:0]     req_ack_q;
    logic                   write_error_q;

    logic                   win_found_d;
    logic [PTR_W-1:0]       win_idx_d;
    logic [NUM_REQ-1:0]     win_onehot_d;
    logic [PTR_W-1:0]       cand_idx;
    logic                   owner_req;
    logic                   owner_last;
    logic [DATA_SIZE-1:0]   owner_data;
    logic                   unused_status;

    assign unused_status = ^{tx_status_i[7:2]};

    // Scan from ptr+1 upward with wrap; the previous owner is the last candidate considered.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = ptr_q;
        cand_idx    = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = (cand_idx == LAST_IDX) ? '0 : cand_idx + PTR_W'(1);
            if (!win_found_d && req_i[cand_idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_idx;
            end
        end
    end

    always_comb begin
        win_onehot_d = '0;
        owner_req    = 1'b0;
        owner_last   = 1'b0;
        owner_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot_d[i] = (win_idx_d == PTR_W'(i));
            if (ptr_q == PTR_W'(i)) begin
                owner_req  = req_i[i];
                owner_last = req_last_i[i];
                owner_data = req_data_i[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            ptr_q         <= LAST_IDX;
            burst_q       <= '0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            write_data_q  <= 1'b0;
            bus_data_q    <= '0;
            req_ack_q     <= '0;
            write_error_q <= 1'b0;
        end else begin
            write_data_q  <= 1'b0;
            req_ack_q     <= '0;
            write_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found_d) begin
                        state_q <= ST_SEND;
                        grant_q <= win_onehot_d;
                        ptr_q   <= win_idx_d;
                        burst_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!owner_req) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (!tx_status_i[1]) begin
                        bus_data_q   <= owner_data;
                        write_data_q <= 1'b1;
                        req_ack_q    <= grant_q;
                        last_q       <= owner_last;
                        burst_q      <= burst_q + BURST_W'(1);
                        state_q      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    write_error_q <= tx_status_i[0];
                    if (last_q || (burst_q == BURST_MAX)) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack_o     = req_ack_q;
    assign grant_o       = grant_q;
    assign busy_o        = busy_q;
    assign write_data_o  = write_data_q;
    assign bus_data_in_o = bus_data_q;
    assign write_error_o = write_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues, strobe log, hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              write_data;
    logic [DW-1:0]     bus_data;
    logic [7:0]        tx_status;
    logic              write_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] src_data [NR][32];
    logic       src_last [NR][32];
    int         src_cnt  [NR];
    int         src_idx  [NR];

    int         log_n = 0;
    int         log_owner [256];
    logic [7:0] log_data  [256];
    int         log_cyc   [256];
    int         err_pulses = 0;

    uart_tx_arbiter dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ack_o     (req_ack),
        .grant_o       (grant),
        .busy_o        (busy),
        .write_data_o  (write_data),
        .bus_data_in_o (bus_data),
        .tx_status_i   (tx_status),
        .write_error_o (write_error)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (src_idx[i] < src_cnt[i]) begin
                req[i]                = 1'b1;
                req_data[i*DW +: DW]  = src_data[i][src_idx[i]];
                req_last[i]           = src_last[i][src_idx[i]];
            end else begin
                req[i]                = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        src_data[r][src_cnt[r]] = d;
        src_last[r][src_cnt[r]] = l;
        src_cnt[r]++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic all_served();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NR; i++) if (src_idx[i] != src_cnt[i]) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_done(input int budget, input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            tick(1);
            done = all_served() && !busy;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick(1);
            seen = write_data;
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic check_entry(input int pos, input int owner, input logic [7:0] d, input string tag);
        check({tag, " owner"}, log_owner[pos], owner);
        check({tag, " data"}, log_data[pos], d);
    endtask

    // Requester model: advance to the next byte at the negedge inside the ack cycle.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NR; i++) if (req_ack[i]) src_idx[i]++;
        drive_reqs();
    end

    // Strobe / error monitor.
    initial forever begin
        int owner;
        @(negedge clk);
        if (write_data) begin
            owner = -1;
            for (int i = 0; i < NR; i++) if (grant[i]) owner = i;
            log_owner[log_n] = owner;
            log_data[log_n]  = bus_data;
            log_cyc[log_n]   = cyc;
            log_n++;
            check("ack matches grant on strobe", req_ack, grant);
        end
        if (write_error) err_pulses++;
    end

    initial begin
        int base;
        int ack0;
        int e0;
        logic [7:0] d;

        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        tx_status = 8'h04;
        for (int i = 0; i < NR; i++) begin src_cnt[i] = 0; src_idx[i] = 0; end

        tick(3);
        check("reset grant", grant, 4'b0000);
        check("reset busy", busy, 1'b0);
        check("reset write_data", write_data, 1'b0);
        check("reset bus_data", bus_data, 8'h00);
        check("reset req_ack", req_ack, 4'b0000);
        check("reset write_error", write_error, 1'b0);
        #1 reset = 1'b0;
        tick(2);

        // Single requester 0, three bytes, last on 0x7E.
        base = log_n;
        #1;
        load(0, 8'hA5, 1'b0); load(0, 8'h3C, 1'b0); load(0, 8'h7E, 1'b1);
        drive_reqs();
        tick(1);
        check("t1 grant at edge N", grant, 4'b0001);
        check("t1 no strobe at edge N", write_data, 1'b0);
        tick(1);
        check("t1 strobe at N+1", write_data, 1'b1);
        check("t1 first byte", bus_data, 8'hA5);
        wait_done(40, "t1 done");
        check("t1 count", log_n - base, 3);
        check_entry(base + 0, 0, 8'hA5, "t1 b0");
        check_entry(base + 1, 0, 8'h3C, "t1 b1");
        check_entry(base + 2, 0, 8'h7E, "t1 b2");
        check("t1 spacing 0-1", log_cyc[base + 1] - log_cyc[base], 3);
        check("t1 spacing 1-2", log_cyc[base + 2] - log_cyc[base + 1], 3);
        check("t1 idle grant", grant, 4'b0000);

        // Requesters 1 and 2 together.
        base = log_n;
        #1;
        load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
        load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b1);
        drive_reqs();
        tick(1);
        check("t2 grant", grant, 4'b0010);
        wait_done(60, "t2 done");
        check("t2 count", log_n - base, 4);
        check_entry(base + 0, 1, 8'h11, "t2 b0");
        check_entry(base + 1, 1, 8'h12, "t2 b1");
        check_entry(base + 2, 2, 8'h21, "t2 b2");
        check_entry(base + 3, 2, 8'h22, "t2 b3");

        // 0/1/2 together after owner 2: order 0, 1, 2.
        base = log_n;
        #1;
        load(0, 8'h01, 1'b1); load(1, 8'h13, 1'b1); load(2, 8'h23, 1'b1);
        drive_reqs();
        wait_done(60, "t2b done");
        check("t2b count", log_n - base, 3);
        check_entry(base + 0, 0, 8'h01, "t2b b0");
        check_entry(base + 1, 1, 8'h13, "t2b b1");
        check_entry(base + 2, 2, 8'h23, "t2b b2");

        // FIFO full held for 50 cycles.
        base = log_n;
        ack0 = src_idx[0];
        #1;
        tx_status = 8'h02;
        load(0, 8'h55, 1'b1);
        drive_reqs();
        tick(50);
        check("t3 no strobe while full", log_n - base, 0);
        check("t3 no ack while full", src_idx[0] - ack0, 0);
        check("t3 grant held", grant, 4'b0001);
        check("t3 busy held", busy, 1'b1);
        #1 tx_status = 8'h00;
        tick(1);
        check("t3 strobe after full clears", write_data, 1'b1);
        check("t3 byte", bus_data, 8'h55);
        wait_done(20, "t3 done");

        // Burst limit: requester 3 streams 20 bytes without last, requester 0 also asks.
        base = log_n;
        #1;
        tx_status = 8'h04;
        for (int i = 0; i < 20; i++) begin
            d = 8'h80 + 8'(i);
            load(3, d, 1'b0);
        end
        load(0, 8'h0F, 1'b1);
        drive_reqs();
        wait_done(300, "t4 done");
        check("t4 count", log_n - base, 21);
        for (int i = 0; i < 16; i++) begin
            d = 8'h80 + 8'(i);
            check_entry(base + i, 3, d, "t4 burst");
        end
        check_entry(base + 16, 0, 8'h0F, "t4 req0 between");
        for (int i = 0; i < 4; i++) begin
            d = 8'h90 + 8'(i);
            check_entry(base + 17 + i, 3, d, "t4 resume");
        end

        // Write error seen during SETTLE of the first byte.
        base = log_n;
        e0 = err_pulses;
        #1;
        load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(1, 8'h43, 1'b1);
        drive_reqs();
        wait_strobe(20, "t5 first strobe");
        tick(1);
        #1 tx_status = 8'h05;
        tick(1);
        check("t5 write_error pulse", write_error, 1'b1);
        #1 tx_status = 8'h04;
        tick(1);
        check("t5 write_error single cycle", write_error, 1'b0);
        wait_done(40, "t5 done");
        check("t5 error pulses", err_pulses - e0, 1);
        check("t5 count", log_n - base, 3);
        check_entry(base + 2, 1, 8'h43, "t5 b2");

        // Reset during STROBE.
        #1;
        load(2, 8'h61, 1'b0); load(2, 8'h62, 1'b1);
        drive_reqs();
        wait_strobe(20, "t6 strobe before reset");
        #1 reset = 1'b1;
        #1;
        check("t6 reset write_data", write_data, 1'b0);
        check("t6 reset req_ack", req_ack, 4'b0000);
        check("t6 reset grant", grant, 4'b0000);
        check("t6 reset busy", busy, 1'b0);
        check("t6 reset bus_data", bus_data, 8'h00);
        for (int i = 0; i < NR; i++) begin src_cnt[i] = 0; src_idx[i] = 0; end
        drive_reqs();
        tick(2);
        base = log_n;
        #1;
        reset = 1'b0;
        load(2, 8'h71, 1'b1); load(0, 8'h72, 1'b1);
        drive_reqs();
        tick(1);
        check("t6 req0 wins after reset", grant, 4'b0001);
        check("t6 no strobe first cycle", write_data, 1'b0);
        wait_done(40, "t6 done");
        check("t6 count", log_n - base, 2);
        check_entry(base + 0, 0, 8'h72, "t6 b0");
        check_entry(base + 1, 2, 8'h71, "t6 b1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
